// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Purpose:
//   Sequences hardware-interrupt entry for the pipelined CPU. A rising edge on
//   the external interrupt pin is latched, and entry waits until no branch,
//   call or return is in flight and the pipeline is not stalled. The block then
//   freezes fetch, lets decode/execute drain for DRAIN_CYCLES cycles, and issues
//   three one-cycle control steps in order: push PC, push flags, load vector.
//
// Parameters:
//   DRAIN_CYCLES   cycles spent in DRAIN (legal range 1..15)
//
// Ports:
//   i_clk            clock, rising edge
//   i_reset          synchronous active-high reset
//   i_interrupt      external interrupt pin (level, rising edges matter)
//   i_pipe_busy      branch/call/return in flight; blocks entry from IDLE
//   i_stall          global stall; freezes the sequencer, blocks entry
//   o_active         sequencer is not in IDLE
//   o_freeze_fetch   hold PC / inject NOP into decode (equals o_active)
//   o_cu_interrupt   control unit interrupt input (PUSH_PC only)
//   o_push_pc        PUSH_PC step
//   o_push_flags     PUSH_FLAGS step
//   o_load_vector    VECTOR step (PC loads from memory address 0)
//
// Build option:
//   INT_PENDING_EN   when defined, a rise seen outside IDLE sets the one-deep
//                    pending flag and is serviced after the current pass;
//                    when undefined, such rises are dropped.
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_interrupt,
  input  logic i_pipe_busy,
  input  logic i_stall,
  output logic o_active,
  output logic o_freeze_fetch,
  output logic o_cu_interrupt,
  output logic o_push_pc,
  output logic o_push_flags,
  output logic o_load_vector
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DRAIN      = 3'd1,
    ST_PUSH_PC    = 3'd2,
    ST_PUSH_FLAGS = 3'd3,
    ST_VECTOR     = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  // Output bundle layout: {active, push_pc, push_flags, load_vector}
  function automatic logic [3:0] decode_outputs(input state_t s);
    logic [3:0] o;
    o = 4'b0000;
    case (s)
      ST_IDLE:       o = 4'b0000;
      ST_DRAIN:      o = 4'b1000;
      ST_PUSH_PC:    o = 4'b1100;
      ST_PUSH_FLAGS: o = 4'b1010;
      ST_VECTOR:     o = 4'b1001;
      default:       o = 4'b0000;
    endcase
    return o;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       int_q;
  logic [3:0] out_q;

  logic rise_s;
  logic late_rise_s;

  assign rise_s = i_interrupt & ~int_q;

`ifdef INT_PENDING_EN
  // Rises while a pass is in progress are remembered for the next pass.
  assign late_rise_s = rise_s & (state_q != ST_IDLE);
`else
  // Rises while a pass is in progress are dropped.
  assign late_rise_s = 1'b0;
`endif

  // Next-state, drain counter and pending flag.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q | late_rise_s;
    case (state_q)
      ST_IDLE: begin
        // A rise in the entry cycle is consumed by the transition itself.
        if ((pending_q | rise_s) & ~i_pipe_busy & ~i_stall) begin
          state_d   = ST_DRAIN;
          cnt_d     = DRAIN_LOAD;
          pending_d = 1'b0;
        end else begin
          pending_d = pending_q | rise_s;
        end
      end
      ST_DRAIN: begin
        if (i_stall) begin
          state_d = ST_DRAIN;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_PUSH_PC;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_PUSH_PC: begin
        if (i_stall) begin
          state_d = ST_PUSH_PC;
        end else begin
          state_d = ST_PUSH_FLAGS;
        end
      end
      ST_PUSH_FLAGS: begin
        if (i_stall) begin
          state_d = ST_PUSH_FLAGS;
        end else begin
          state_d = ST_VECTOR;
        end
      end
      ST_VECTOR: begin
        if (i_stall) begin
          state_d = ST_VECTOR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = 4'd0;
        pending_d = 1'b0;
      end
    endcase
  end

  // State, counter, pending and edge-detect registers. Outputs are registered
  // from the next state so they line up with the state they describe.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      pending_q <= 1'b0;
      int_q     <= 1'b0;
      out_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      int_q     <= i_interrupt;
      out_q     <= decode_outputs(state_d);
    end
  end

  assign o_active       = out_q[3];
  assign o_freeze_fetch = out_q[3];
  assign o_push_pc      = out_q[2];
  assign o_cu_interrupt = out_q[2];
  assign o_push_flags   = out_q[1];
  assign o_load_vector  = out_q[0];

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

  localparam int D = 3;
`ifdef INT_PENDING_EN
  localparam bit PEND_EN = 1'b1;
`else
  localparam bit PEND_EN = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_reset, i_interrupt, i_pipe_busy, i_stall;
  logic o_active, o_freeze_fetch, o_cu_interrupt, o_push_pc, o_push_flags, o_load_vector;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: position in the entry sequence.
  // 0 = idle, 1..D = drain cycles, D+1 = push PC, D+2 = push flags, D+3 = vector.
  int m_pos  = 0;
  bit m_pend = 1'b0;
  bit m_prev = 1'b0;

  interrupt_sequencer #(.DRAIN_CYCLES(D)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_interrupt(i_interrupt),
    .i_pipe_busy(i_pipe_busy), .i_stall(i_stall),
    .o_active(o_active), .o_freeze_fetch(o_freeze_fetch),
    .o_cu_interrupt(o_cu_interrupt), .o_push_pc(o_push_pc),
    .o_push_flags(o_push_flags), .o_load_vector(o_load_vector)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [5:0] got_vec();
    return {o_active, o_freeze_fetch, o_cu_interrupt, o_push_pc, o_push_flags, o_load_vector};
  endfunction

  function automatic logic [5:0] model_vec();
    logic a, pc, pf, lv;
    a  = (m_pos != 0);
    pc = (m_pos == D + 1);
    pf = (m_pos == D + 2);
    lv = (m_pos == D + 3);
    return {a, a, pc, pc, pf, lv};
  endfunction

  // One clock edge: advance the model with the inputs present at the edge,
  // then wait a little so outputs are sampled away from the edge.
  task automatic tick();
    bit rise;
    @(posedge i_clk);
    rise = i_interrupt && !m_prev;
    if (i_reset) begin
      m_pos = 0; m_pend = 1'b0; m_prev = 1'b0;
    end else begin
      if (m_pos == 0) begin
        if ((m_pend || rise) && !i_pipe_busy && !i_stall) begin
          m_pos = 1; m_pend = 1'b0;
        end else begin
          m_pend = m_pend || rise;
        end
      end else begin
        if (rise && PEND_EN) m_pend = 1'b1;
        if (!i_stall) m_pos = (m_pos == D + 3) ? 0 : m_pos + 1;
      end
      m_prev = i_interrupt;
    end
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_interrupt = 1'b0; i_pipe_busy = 1'b0; i_stall = 1'b0;
    tick(); tick();
    n_tests++;
    if (got_vec() !== 6'b000000) begin
      n_fail++; $display("FAIL reset_outputs got %b exp 000000", got_vec());
    end
    i_reset = 1'b0;
    tick();
    n_tests++;
    if (got_vec() !== 6'b000000) begin
      n_fail++; $display("FAIL reset_idle got %b exp 000000", got_vec());
    end
  endtask

  task automatic test_basic();
    logic [5:0] exp;
    i_interrupt = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      i_interrupt = 1'b0;
      exp = 6'b000000;
      if (k <= 6) exp[5:4] = 2'b11;
      if (k == 4) exp[3:2] = 2'b11;
      if (k == 5) exp[1] = 1'b1;
      if (k == 6) exp[0] = 1'b1;
      n_tests++;
      if (got_vec() !== exp) begin
        n_fail++; $display("FAIL basic_cycle%0d got %b exp %b", k, got_vec(), exp);
      end
    end
  endtask

  task automatic test_busy();
    i_pipe_busy = 1'b1; i_interrupt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      i_interrupt = 1'b0;
      n_tests++;
      if (got_vec() !== 6'b000000) begin
        n_fail++; $display("FAIL busy_hold%0d got %b exp 000000", k, got_vec());
      end
    end
    i_pipe_busy = 1'b0;
    tick();
    n_tests++;
    if (got_vec() !== 6'b110000) begin
      n_fail++; $display("FAIL busy_release got %b exp 110000", got_vec());
    end
    for (int k = 0; k < 6; k++) tick();
    n_tests++;
    if (o_active !== 1'b0) begin
      n_fail++; $display("FAIL busy_done got %b exp 0", o_active);
    end
  endtask

  task automatic test_stall();
    i_interrupt = 1'b1;
    tick();
    i_interrupt = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    n_tests++;
    if (got_vec() !== 6'b110010) begin
      n_fail++; $display("FAIL stall_flags1 got %b exp 110010", got_vec());
    end
    i_stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (got_vec() !== 6'b110010) begin
        n_fail++; $display("FAIL stall_flags_hold%0d got %b exp 110010", k, got_vec());
      end
    end
    i_stall = 1'b0;
    tick();
    n_tests++;
    if (got_vec() !== 6'b110001) begin
      n_fail++; $display("FAIL stall_vector got %b exp 110001", got_vec());
    end
    tick();
    n_tests++;
    if (got_vec() !== 6'b000000) begin
      n_fail++; $display("FAIL stall_idle got %b exp 000000", got_vec());
    end
  endtask

  task automatic test_second_rise();
    logic exp_act;
    i_interrupt = 1'b1; tick();
    i_interrupt = 1'b0; tick();
    i_interrupt = 1'b1; tick();
    i_interrupt = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_tests++;
    if (o_load_vector !== 1'b1) begin
      n_fail++; $display("FAIL second_vector got %b exp 1", o_load_vector);
    end
    tick();
    n_tests++;
    if (o_active !== 1'b0) begin
      n_fail++; $display("FAIL second_gap got %b exp 0", o_active);
    end
    tick();
    exp_act = PEND_EN;
    n_tests++;
    if (o_active !== exp_act) begin
      n_fail++; $display("FAIL second_reentry got %b exp %b", o_active, exp_act);
    end
    for (int k = 0; k < 7; k++) tick();
    n_tests++;
    if (o_active !== 1'b0) begin
      n_fail++; $display("FAIL second_done got %b exp 0", o_active);
    end
  endtask

  task automatic test_reset_mid();
    i_interrupt = 1'b1; tick();
    i_interrupt = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    n_tests++;
    if (got_vec() !== 6'b111100) begin
      n_fail++; $display("FAIL mid_pushpc got %b exp 111100", got_vec());
    end
    i_reset = 1'b1; i_interrupt = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if (got_vec() !== 6'b000000) begin
        n_fail++; $display("FAIL mid_reset%0d got %b exp 000000", k, got_vec());
      end
    end
    i_reset = 1'b0;
    tick();
    n_tests++;
    if (got_vec() !== 6'b110000) begin
      n_fail++; $display("FAIL mid_reentry got %b exp 110000", got_vec());
    end
    i_interrupt = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    n_tests++;
    if (o_active !== 1'b0) begin
      n_fail++; $display("FAIL mid_done got %b exp 0", o_active);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      i_reset     = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) i_interrupt = ~i_interrupt;
      i_pipe_busy = ($urandom_range(0, 2) == 0);
      i_stall     = ($urandom_range(0, 4) == 0);
      tick();
      n_tests++;
      if (got_vec() !== model_vec()) begin
        n_fail++; $display("FAIL random_cycle%0d got %b exp %b", k, got_vec(), model_vec());
      end
    end
    i_reset = 1'b0; i_interrupt = 1'b0; i_pipe_busy = 1'b0; i_stall = 1'b0;
  endtask

  initial begin
    i_reset = 1'b1; i_interrupt = 1'b0; i_pipe_busy = 1'b0; i_stall = 1'b0;
    test_reset();
    test_basic();
    test_busy();
    test_stall();
    test_second_rise();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
